// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - frame-buffer read side driving a 640x480@60 VGA DAC
module vga_scanout #(
    parameter int         H_VISIBLE    = 640,
    parameter int         H_FRONT      = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BACK       = 48,
    parameter int         V_VISIBLE    = 480,
    parameter int         V_FRONT      = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BACK       = 33,
    parameter int         WIN_X        = 192,
    parameter int         WIN_Y        = 112,
    parameter int         FB_BITS      = 7,
    parameter logic [2:0] BORDER_COLOR = 3'b000
) (
    input  logic                   Clck,
    input  logic                   Reset,
    output logic [2*FB_BITS-1:0]   read_address,
    input  logic [2:0]             read_data,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_clk,
    output logic                   frame_done
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int WIN_SIZE = 2 << FB_BITS;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] WX_FIRST = 10'(WIN_X);
    localparam logic [9:0] WX_LAST  = 10'(WIN_X + WIN_SIZE - 1);
    localparam logic [9:0] WY_FIRST = 10'(WIN_Y);
    localparam logic [9:0] WY_LAST  = 10'(WIN_Y + WIN_SIZE - 1);

    logic               pix_phase;
    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic [9:0]         h_next;
    logic [9:0]         v_next;
    logic               h_wrap;
    logic               next_in_win;
    logic               cur_in_win;
    logic               visible;
    logic [FB_BITS-1:0] h_fb;
    logic [FB_BITS-1:0] v_fb;
    logic [2:0]         colour;

    function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
        return (h >= WX_FIRST) && (h <= WX_LAST) && (v >= WY_FIRST) && (v <= WY_LAST);
    endfunction

    assign vga_clk = pix_phase;

    always_comb begin
        h_wrap      = (h_cnt == H_LAST);
        h_next      = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next      = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
        next_in_win = in_window(h_next, v_next);
        // Each frame-buffer word covers a 2x2 block of raster pixels.
        h_fb        = FB_BITS'((h_next - WX_FIRST) >> 1);
        v_fb        = FB_BITS'((v_next - WY_FIRST) >> 1);
        cur_in_win  = in_window(h_cnt, v_cnt);
        visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        colour      = 3'b000;
        if (visible) begin
            colour = cur_in_win ? read_data : BORDER_COLOR;
        end
    end

    // Counters still hold the pixel whose address went out one update earlier,
    // so decoding them here keeps colour, sync and blank aligned.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            pix_phase    <= 1'b0;
            h_cnt        <= 10'd0;
            v_cnt        <= 10'd0;
            read_address <= '0;
            vga_r        <= 8'd0;
            vga_g        <= 8'd0;
            vga_b        <= 8'd0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_blank_n  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            pix_phase  <= ~pix_phase;
            frame_done <= 1'b0;
            if (pix_phase) begin
                h_cnt <= h_next;
                v_cnt <= v_next;
                if (next_in_win) begin
                    read_address <= {v_fb, h_fb};
                end
                vga_r       <= {8{colour[2]}};
                vga_g       <= {8{colour[1]}};
                vga_b       <= {8{colour[0]}};
                vga_blank_n <= visible;
                vga_hs      <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
                vga_vs      <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
                frame_done  <= h_wrap && (v_cnt == V_VIS_M1);
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed self-checking bench for vga_scanout
module tb_vga_scanout;

    // Shrunk raster: 48 pixels x 31 lines, 16x16 window at (8,4), 8x8 buffer.
    localparam int S_FRAME = 2 * 48 * 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          ecnt = 0;
    int          checks = 0;
    int          errors = 0;

    logic [5:0]  s_addr;
    logic [2:0]  s_rd = 3'b000;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_bn, s_vclk, s_fd;

    logic [13:0] f_addr;
    logic [2:0]  f_rd = 3'b000;
    logic [7:0]  f_r, f_g, f_b;
    logic        f_hs, f_vs, f_bn, f_vclk, f_fd;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .WIN_X(8), .WIN_Y(4), .FB_BITS(3), .BORDER_COLOR(3'b110)
    ) dut (
        .Clck(clk), .Reset(rst_n), .read_address(s_addr), .read_data(s_rd),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_bn), .vga_clk(s_vclk), .frame_done(s_fd)
    );

    vga_scanout dut_full (
        .Clck(clk), .Reset(rst_n), .read_address(f_addr), .read_data(f_rd),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hs(f_hs), .vga_vs(f_vs),
        .vga_blank_n(f_bn), .vga_clk(f_vclk), .frame_done(f_fd)
    );

    // Memory returns the low address bits as colour, one Clck later.
    always @(posedge clk) begin
        s_rd <= s_addr[2:0];
        f_rd <= f_addr[2:0];
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    int   brise[2], bfall[2], hfall[2], hrise[2];
    int   nbr = 0, nbf = 0, nhf = 0, nhr = 0;
    int   fd_t[4];
    int   fd_n = 0, fd_wide = 0;
    int   vfall = 0, vrise = 0;
    logic vf_seen = 1'b0, vr_seen = 1'b0;
    logic f_bn_q = 1'b0, f_hs_q = 1'b1, s_fd_q = 1'b0, s_vs_q = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (f_bn && !f_bn_q && nbr < 2) begin brise[nbr] <= ecnt; nbr <= nbr + 1; end
            if (!f_bn && f_bn_q && nbf < 2) begin bfall[nbf] <= ecnt; nbf <= nbf + 1; end
            if (!f_hs && f_hs_q && nhf < 2) begin hfall[nhf] <= ecnt; nhf <= nhf + 1; end
            if (f_hs && !f_hs_q && nhr < 2) begin hrise[nhr] <= ecnt; nhr <= nhr + 1; end
            if (s_fd) begin
                if (fd_n < 4) fd_t[fd_n] <= ecnt;
                fd_n <= fd_n + 1;
            end
            if (s_fd && s_fd_q) fd_wide <= fd_wide + 1;
            if (!s_vs && s_vs_q && !vf_seen) begin vfall <= ecnt; vf_seen <= 1'b1; end
            if (s_vs && !s_vs_q && vf_seen && !vr_seen) begin vrise <= ecnt; vr_seen <= 1'b1; end
        end
        f_bn_q <= f_bn;
        f_hs_q <= f_hs;
        s_fd_q <= s_fd;
        s_vs_q <= s_vs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hs", 32'(s_hs), 1);
        chk("rst_vs", 32'(s_vs), 1);
        chk("rst_blank", 32'(s_bn), 0);
        chk("rst_rgb", 32'({s_r, s_g, s_b}), 0);
        chk("rst_fd", 32'(s_fd), 0);
        chk("rst_addr", 32'(s_addr), 0);
        chk("rst_vclk", 32'(s_vclk), 0);
        chk("rst_full_hs", 32'(f_hs), 1);
        rst_n = 1'b1;

        wait_to(1);
        chk("e1_vclk", 32'(s_vclk), 1);
        chk("e1_blank", 32'(s_bn), 0);
        chk("e1_rgb", 32'({s_r, s_g, s_b}), 0);
        wait_to(2);
        chk("e2_vclk", 32'(s_vclk), 0);
        chk("px0_blank", 32'(s_bn), 1);
        chk("px0_border", 32'({s_r, s_g, s_b}), 32'h00ffff00);
        wait_to(274);
        chk("px40_2_blank", 32'(s_bn), 0);
        chk("px40_2_rgb", 32'({s_r, s_g, s_b}), 0);
        chk("px40_2_hs", 32'(s_hs), 0);
        wait_to(400);
        chk("addr_8_4", 32'(s_addr), 0);
        wait_to(408);
        chk("addr_12_4", 32'(s_addr), 2);
        wait_to(410);
        chk("rgb_12_4", 32'({s_r, s_g, s_b}), 32'h0000ff00);
        wait_to(498);
        chk("addr_9_5", 32'(s_addr), 0);
        wait_to(596);
        chk("addr_10_6", 32'(s_addr), 9);
        wait_to(598);
        chk("rgb_10_6", 32'({s_r, s_g, s_b}), 32'h000000ff);
        wait_to(1870);
        chk("addr_23_19", 32'(s_addr), 63);
        wait_to(1872);
        chk("rgb_23_19", 32'({s_r, s_g, s_b}), 32'h00ffffff);
        chk("addr_hold_24_19", 32'(s_addr), 63);
        wait_to(1874);
        chk("rgb_24_19_border", 32'({s_r, s_g, s_b}), 32'h00ffff00);

        wait_to(3300);
        chk("full_blank_rise0", 32'(brise[0]), 2);
        chk("full_blank_high0", 32'(bfall[0] - brise[0]), 1280);
        chk("full_hs_fall0_abs", 32'(hfall[0]), 1314);
        chk("full_hs_fall0_rel", 32'(hfall[0] - brise[0]), 1312);
        chk("full_hs_low0", 32'(hrise[0] - hfall[0]), 192);
        chk("full_line_period", 32'(brise[1] - brise[0]), 1600);
        chk("full_blank_high1", 32'(bfall[1] - brise[1]), 1280);
        chk("full_hs_fall1_rel", 32'(hfall[1] - brise[1]), 1312);
        chk("full_hs_low1", 32'(hrise[1] - hfall[1]), 192);

        wait_to(5400);
        chk("fd_count", 32'(fd_n), 2);
        chk("fd_first", 32'(fd_t[0]), 2304);
        chk("fd_period", 32'(fd_t[1] - fd_t[0]), S_FRAME);
        chk("fd_width", 32'(fd_wide), 0);
        chk("vs_fall", 32'(vfall), 2498);
        chk("vs_low", 32'(vrise - vfall), 192);

        // Reset at raster (30,23) of the third frame, just before frame_done.
        wait_to(2 * (2 * 1488 + 23 * 48 + 30));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(s_addr), 0);
        chk("mid_rst_hs", 32'(s_hs), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_fd", 32'(s_fd), 0);
            chk("mid_rst_blank", 32'(s_bn), 0);
        end
        rst_n = 1'b1;
        wait_to(2);
        chk("restart_blank", 32'(s_bn), 1);
        chk("restart_border", 32'({s_r, s_g, s_b}), 32'h00ffff00);
        wait_to(2303);
        chk("restart_no_fd", 32'(fd_n), 2);
        wait_to(2304);
        chk("restart_fd", 32'(s_fd), 1);
        wait_to(2310);
        chk("restart_fd_count", 32'(fd_n), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
